fetch_ctrl: RTL and testbench

//  Fetch sequencer for the MIPS core: owns the PC and drives a word-wide instruction memory over a req/ack handshake.

---
 rtl/fetch_ctrl.sv | 116 +++++++++++
 tb/tb_fetch_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, fetches one word per request over req/ack, holds it until decode takes it.
// Optional build macro FETCH_CHK_EN adds alignment/range checking of every new PC with a sticky fault.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              id_ready,
  output logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              fetch_fault
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_VALID, S_FAULT} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        req_q;
  logic        fault_q;
  logic        redir_pend_q;
  logic [31:0] redir_pc_q;

  logic [31:0] raw_pc;
  logic [31:0] pc_d;
  logic        pc_bad;

  // Candidate PC for any load this cycle: a live redirect beats a pending one and beats pc+4.
  assign raw_pc = redirect_valid              ? redirect_pc :
                  (state_q == S_VALID)        ? pc_q + 32'd4 :
                                                redir_pc_q;

`ifdef FETCH_CHK_EN
  assign pc_d   = raw_pc;
  assign pc_bad = (raw_pc[1:0] != 2'b00) ||
                  (((raw_pc - IM_BASE) >> (ADDR_W + 2)) != 32'd0);
`else
  assign pc_d   = raw_pc & ~32'd3;
  assign pc_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      valid_q      <= 1'b0;
      req_q        <= 1'b0;
      fault_q      <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (mem_ack) begin
            if (redirect_valid || redir_pend_q) begin
              // Stale fetch: drop the data and refetch at the redirect target.
              redir_pend_q <= 1'b0;
              pc_q         <= pc_d;
              if (pc_bad) begin
                state_q <= S_FAULT;
                fault_q <= 1'b1;
                req_q   <= 1'b0;
              end
            end else begin
              instr_q <= mem_rdata;
              valid_q <= 1'b1;
              req_q   <= 1'b0;
              state_q <= S_VALID;
            end
          end else if (redirect_valid) begin
            redir_pend_q <= 1'b1;
            redir_pc_q   <= redirect_pc;
          end
        end
        S_VALID: begin
          if (redirect_valid || id_ready) begin
            valid_q <= 1'b0;
            pc_q    <= pc_d;
            if (pc_bad) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign mem_req     = req_q;
  assign mem_addr    = ADDR_W'((pc_q - IM_BASE) >> 2);
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; memory word n returns 32'hC0DE_0000 | n.
// Build with +define+FETCH_CHK_EN to exercise the checked-PC variant.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        fetch_fault;

  int total = 0;
  int bad   = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_3000), .IM_BASE(32'h0000_3000), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  assign mem_rdata = 32'hC0DE_0000 | {20'd0, mem_addr};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_fetch(input string tag, input logic [31:0] e_pc,
                             input logic e_req, input logic e_valid);
    check({tag, "_pc"}, pc, e_pc);
    check({tag, "_req"}, {31'd0, mem_req}, {31'd0, e_req});
    check({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
  endtask

  initial begin
    rst = 1'b1; mem_ack = 1'b1; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    check_fetch("rst", 32'h3000, 1'b0, 1'b0);
    check("rst_instr", instr, 32'h0);
    check("rst_fault", {31'd0, fetch_fault}, 32'd0);

    // 1) streaming with ack in the request cycle
    rst = 1'b0;
    tick();
    check_fetch("t1_req0", 32'h3000, 1'b1, 1'b0);
    check("t1_addr0", {20'd0, mem_addr}, 32'h000);
    tick();
    check_fetch("t1_val0", 32'h3000, 1'b0, 1'b1);
    check("t1_instr0", instr, 32'hC0DE_0000);
    tick();
    check_fetch("t1_req1", 32'h3004, 1'b1, 1'b0);
    check("t1_addr1", {20'd0, mem_addr}, 32'h001);
    tick();
    check("t1_instr1", instr, 32'hC0DE_0001);
    tick(); tick();
    check_fetch("t1_val2", 32'h3008, 1'b0, 1'b1);
    check("t1_instr2", instr, 32'hC0DE_0002);

    // 2) decode stall holds everything
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_fetch("t2_hold", 32'h3008, 1'b0, 1'b1);
      check("t2_hold_instr", instr, 32'hC0DE_0002);
    end
    id_ready = 1'b1;
    tick();
    check_fetch("t2_release", 32'h300C, 1'b1, 1'b0);

    // 3) redirect while ack is delayed: returned data is discarded
    mem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h3100;
    tick();
    check_fetch("t3_pend", 32'h300C, 1'b1, 1'b0);
    check("t3_addr_held", {20'd0, mem_addr}, 32'h003);
    redirect_valid = 1'b0;
    tick(); tick();
    check_fetch("t3_wait", 32'h300C, 1'b1, 1'b0);
    mem_ack = 1'b1;
    tick();
    check_fetch("t3_discard", 32'h3100, 1'b1, 1'b0);
    check("t3_addr", {20'd0, mem_addr}, 32'h040);
    tick();
    check_fetch("t3_val", 32'h3100, 1'b0, 1'b1);
    check("t3_instr", instr, 32'hC0DE_0040);

    // 4) redirect beats consume; then redirect with same-cycle ack
    redirect_valid = 1'b1; redirect_pc = 32'h3200;
    tick();
    check_fetch("t4_redir", 32'h3200, 1'b1, 1'b0);
    check("t4_addr", {20'd0, mem_addr}, 32'h080);
    redirect_pc = 32'h3300;
    tick();
    check_fetch("t4_ackredir", 32'h3300, 1'b1, 1'b0);
    check("t4_instr_kept", instr, 32'hC0DE_0040);
    redirect_valid = 1'b0;
    tick();
    check_fetch("t4_val", 32'h3300, 1'b0, 1'b1);
    check("t4_instr", instr, 32'hC0DE_00C0);

    // later pending redirect overwrites the earlier one
    mem_ack = 1'b0;
    tick();
    check_fetch("t4b_req", 32'h3304, 1'b1, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h3400;
    tick();
    redirect_pc = 32'h3500;
    tick();
    redirect_valid = 1'b0; mem_ack = 1'b1;
    tick();
    check_fetch("t4b_over", 32'h3500, 1'b1, 1'b0);
    check("t4b_addr", {20'd0, mem_addr}, 32'h140);
    tick();
    check("t4b_instr", instr, 32'hC0DE_0140);

    // 5) reset during a pending request
    mem_ack = 1'b0;
    tick();
    check_fetch("t5_req", 32'h3504, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    check_fetch("t5_rst", 32'h3000, 1'b0, 1'b0);
    rst = 1'b0; mem_ack = 1'b1;
    tick();
    check_fetch("t5_late_ack", 32'h3000, 1'b1, 1'b0);
    tick();
    check_fetch("t5_val", 32'h3000, 1'b0, 1'b1);
    check("t5_instr", instr, 32'hC0DE_0000);

    // 6) misaligned redirect
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h3102;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_CHK_EN
    check_fetch("t6_fault", 32'h3102, 1'b0, 1'b0);
    check("t6_fault_flag", {31'd0, fetch_fault}, 32'd1);
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fetch("t6_stuck", 32'h3102, 1'b0, 1'b0);
      check("t6_sticky", {31'd0, fetch_fault}, 32'd1);
    end
`else
    check_fetch("t6_align", 32'h3100, 1'b1, 1'b0);
    check("t6_addr", {20'd0, mem_addr}, 32'h040);
    check("t6_nofault", {31'd0, fetch_fault}, 32'd0);
    tick();
    check("t6_instr", instr, 32'hC0DE_0040);
    // out-of-range target wraps the word index
    redirect_valid = 1'b1; redirect_pc = 32'h7004;
    tick();
    redirect_valid = 1'b0;
    check_fetch("t6_wrap", 32'h7004, 1'b1, 1'b0);
    check("t6_wrap_addr", {20'd0, mem_addr}, 32'h001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
